control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_control_fsm.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// LC-3b multicycle control unit: fetch/decode/execute sequencer with datapath selects,
// register enables and a per-access memory timeout that parks the FSM in a sticky fault.
module control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       imm_check,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_regfile,
  output logic       load_cc,
  output logic       mem_read,
  output logic       mem_write,
  output logic       pcmux_sel,
  output logic       sr2mux_sel,
  output logic       addr1mux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic       regfilemux_sel,
  output logic [1:0] addr2mux_sel,
  output logic [2:0] aluop,
  output logic       insn_done,
  output logic       illegal_op,
  output logic       mem_fault
);

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpNot = 4'b1001;

  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluAnd  = 3'd1;
  localparam logic [2:0] AluNot  = 3'd2;
  localparam logic [2:0] AluPass = 3'd3;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    StFetch1, StFetch2, StFetch3, StDecode, StAlu, StCalcAddr,
    StLdr1, StLdr2, StStr1, StStr2, StBr, StFault
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic             w_timeout;
  logic             w_legal;

  assign w_timeout = (r_cnt == TimeoutVal);

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OpAdd, OpAnd, OpNot, OpLdr, OpStr, OpBr: w_legal = 1'b1;
      default:                                 w_legal = 1'b0;
    endcase
  end

  // Counter is cleared by the state preceding each wait state, so it reads 0 on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StFetch1;
      r_cnt   <= '0;
      r_op    <= '0;
    end else begin
      unique case (r_state)
        StFetch1: begin
          r_cnt   <= '0;
          r_state <= StFetch2;
        end
        StFetch2: begin
          if (mem_resp)       r_state <= StFetch3;
          else if (w_timeout) r_state <= StFault;
          else                r_cnt   <= r_cnt + 1'b1;
        end
        StFetch3: r_state <= StDecode;
        StDecode: begin
          r_op <= opcode;
          case (opcode)
            OpAdd, OpAnd, OpNot: r_state <= StAlu;
            OpLdr, OpStr:        r_state <= StCalcAddr;
            OpBr:                r_state <= StBr;
            default:             r_state <= StFetch1;
          endcase
        end
        StAlu: r_state <= StFetch1;
        StCalcAddr: begin
          r_cnt   <= '0;
          r_state <= (r_op == OpLdr) ? StLdr1 : StStr1;
        end
        StLdr1: begin
          if (mem_resp)       r_state <= StLdr2;
          else if (w_timeout) r_state <= StFault;
          else                r_cnt   <= r_cnt + 1'b1;
        end
        StLdr2: r_state <= StFetch1;
        StStr1: begin
          r_cnt   <= '0;
          r_state <= StStr2;
        end
        StStr2: begin
          if (mem_resp)       r_state <= StFetch1;
          else if (w_timeout) r_state <= StFault;
          else                r_cnt   <= r_cnt + 1'b1;
        end
        StBr:    r_state <= StFetch1;
        StFault: r_state <= StFault;
        default: r_state <= StFetch1;
      endcase
    end
  end

  // Outputs decode from the current state; load_mdr follows mem_resp in the same cycle.
  always_comb begin
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_regfile   = 1'b0;
    load_cc        = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    pcmux_sel      = 1'b0;
    sr2mux_sel     = 1'b0;
    addr1mux_sel   = 1'b0;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    regfilemux_sel = 1'b0;
    addr2mux_sel   = 2'b00;
    aluop          = AluPass;
    insn_done      = 1'b0;
    illegal_op     = 1'b0;
    mem_fault      = 1'b0;
    unique case (r_state)
      StFetch1: begin
        load_mar = 1'b1;
        load_pc  = 1'b1;
      end
      StFetch2: begin
        mem_read = 1'b1;
        load_mdr = mem_resp;
      end
      StFetch3: load_ir = 1'b1;
      StDecode: illegal_op = ~w_legal;
      StAlu: begin
        load_regfile = 1'b1;
        load_cc      = 1'b1;
        insn_done    = 1'b1;
        case (r_op)
          OpAdd: begin
            aluop      = AluAdd;
            sr2mux_sel = imm_check;
          end
          OpAnd: begin
            aluop      = AluAnd;
            sr2mux_sel = imm_check;
          end
          default: aluop = AluNot;
        endcase
      end
      StCalcAddr: begin
        addr1mux_sel = 1'b1;
        addr2mux_sel = 2'b01;
        marmux_sel   = 1'b1;
        load_mar     = 1'b1;
      end
      StLdr1: begin
        mem_read   = 1'b1;
        mdrmux_sel = 1'b1;
        load_mdr   = mem_resp;
      end
      StLdr2: begin
        regfilemux_sel = 1'b1;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
        insn_done      = 1'b1;
      end
      StStr1: load_mdr = 1'b1;
      StStr2: begin
        mem_write = 1'b1;
        insn_done = mem_resp;
      end
      StBr: begin
        insn_done = 1'b1;
        if (branch_enable) begin
          addr2mux_sel = 2'b10;
          pcmux_sel    = 1'b1;
          load_pc      = 1'b1;
        end
      end
      StFault: mem_fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction cycle-trace model driven by random opcodes and
// memory latencies, compared cycle by cycle against every DUT output.
module tb_control_fsm;

  localparam int unsigned TMO = 4;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_NOT  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_mar;
    logic       load_mdr;
    logic       load_regfile;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic       pcmux_sel;
    logic       sr2mux_sel;
    logic       addr1mux_sel;
    logic       marmux_sel;
    logic       mdrmux_sel;
    logic       regfilemux_sel;
    logic [1:0] addr2mux_sel;
    logic [2:0] aluop;
    logic       insn_done;
    logic       illegal_op;
    logic       mem_fault;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       imm_check;
  logic       branch_enable;
  logic       mem_resp;
  logic       load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc;
  logic       mem_read, mem_write;
  logic       pcmux_sel, sr2mux_sel, addr1mux_sel, marmux_sel, mdrmux_sel, regfilemux_sel;
  logic [1:0] addr2mux_sel;
  logic [2:0] aluop;
  logic       insn_done, illegal_op, mem_fault;
  outs_t      obs;

  int n_cmp = 0;
  int n_err = 0;

  control_fsm #(
    .MEM_TIMEOUT(TMO),
    .CNT_W      (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .imm_check     (imm_check),
    .branch_enable (branch_enable),
    .mem_resp      (mem_resp),
    .load_pc       (load_pc),
    .load_ir       (load_ir),
    .load_mar      (load_mar),
    .load_mdr      (load_mdr),
    .load_regfile  (load_regfile),
    .load_cc       (load_cc),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .pcmux_sel     (pcmux_sel),
    .sr2mux_sel    (sr2mux_sel),
    .addr1mux_sel  (addr1mux_sel),
    .marmux_sel    (marmux_sel),
    .mdrmux_sel    (mdrmux_sel),
    .regfilemux_sel(regfilemux_sel),
    .addr2mux_sel  (addr2mux_sel),
    .aluop         (aluop),
    .insn_done     (insn_done),
    .illegal_op    (illegal_op),
    .mem_fault     (mem_fault)
  );

  always #5 clk = ~clk;

  assign obs = {load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc, mem_read, mem_write,
                pcmux_sel, sr2mux_sel, addr1mux_sel, marmux_sel, mdrmux_sel, regfilemux_sel,
                addr2mux_sel, aluop, insn_done, illegal_op, mem_fault};

  // Expected output vectors, one per step of the instruction flow.
  function automatic outs_t blank();
    outs_t o = '0;
    o.aluop = ALU_PASS;
    return o;
  endfunction

  function automatic outs_t v_fetch1();
    outs_t o = blank();
    o.load_mar = 1'b1;
    o.load_pc  = 1'b1;
    return o;
  endfunction

  function automatic outs_t v_fetch3();
    outs_t o = blank();
    o.load_ir = 1'b1;
    return o;
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return op == OP_ADD || op == OP_AND || op == OP_NOT || op == OP_LDR || op == OP_STR ||
           op == OP_BR;
  endfunction

  function automatic outs_t v_decode(input logic [3:0] op);
    outs_t o = blank();
    o.illegal_op = !is_legal(op);
    return o;
  endfunction

  function automatic outs_t v_alu(input logic [3:0] op, input logic imm);
    outs_t o = blank();
    o.load_regfile = 1'b1;
    o.load_cc      = 1'b1;
    o.insn_done    = 1'b1;
    o.aluop        = (op == OP_ADD) ? ALU_ADD : (op == OP_AND) ? ALU_AND : ALU_NOT;
    o.sr2mux_sel   = (op != OP_NOT) && imm;
    return o;
  endfunction

  function automatic outs_t v_calc();
    outs_t o = blank();
    o.addr1mux_sel = 1'b1;
    o.addr2mux_sel = 2'b01;
    o.marmux_sel   = 1'b1;
    o.load_mar     = 1'b1;
    return o;
  endfunction

  function automatic outs_t v_ldr2();
    outs_t o = blank();
    o.regfilemux_sel = 1'b1;
    o.load_regfile   = 1'b1;
    o.load_cc        = 1'b1;
    o.insn_done      = 1'b1;
    return o;
  endfunction

  function automatic outs_t v_str1();
    outs_t o = blank();
    o.load_mdr = 1'b1;
    return o;
  endfunction

  function automatic outs_t v_br(input logic taken);
    outs_t o = blank();
    o.insn_done = 1'b1;
    if (taken) begin
      o.addr2mux_sel = 2'b10;
      o.pcmux_sel    = 1'b1;
      o.load_pc      = 1'b1;
    end
    return o;
  endfunction

  function automatic outs_t v_fault();
    outs_t o = blank();
    o.mem_fault = 1'b1;
    return o;
  endfunction

  // kind 0 = instruction fetch, 1 = load read, 2 = store write
  function automatic outs_t v_wait(input int kind, input logic resp);
    outs_t o = blank();
    if (kind == 2) begin
      o.mem_write = 1'b1;
      o.insn_done = resp;
    end else begin
      o.mem_read   = 1'b1;
      o.load_mdr   = resp;
      o.mdrmux_sel = (kind == 1);
    end
    return o;
  endfunction

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input outs_t got, input outs_t exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entered and left at posedge+1; outputs sampled at the falling edge.
  task automatic step(input logic resp, input outs_t exp, input string tag);
    mem_resp = resp;
    @(negedge clk);
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  // A memory access answers after 'delay' idle cycles; more than TMO idle cycles means fault.
  task automatic wait_phase(input int kind, input int delay, output bit faulted);
    faulted = 1'b0;
    for (int i = 0; i <= int'(TMO); i++) begin
      if (i < delay) begin
        step(1'b0, v_wait(kind, 1'b0), "wait_idle");
      end else begin
        step(1'b1, v_wait(kind, 1'b1), "wait_resp");
        return;
      end
    end
    faulted = 1'b1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    mem_resp = 1'b0;
    #1;
    check("in_reset", obs, v_fetch1());
    @(posedge clk);
    #1;
    mem_resp = 1'b1;
    #1;
    check("reset_hold", obs, v_fetch1());
    reset = 1'b0;
  endtask

  task automatic fault_tail();
    for (int i = 0; i < 3; i++) step(noise(), v_fault(), "fault_sticky");
    do_reset();
  endtask

  task automatic run_instr(input logic [3:0] op, input logic imm, input logic br,
                           input int d_fetch, input int d_mem);
    bit f;
    opcode        = op;
    imm_check     = imm;
    branch_enable = br;
    step(noise(), v_fetch1(), "fetch1");
    wait_phase(0, d_fetch, f);
    if (f) begin
      fault_tail();
      return;
    end
    step(noise(), v_fetch3(), "fetch3");
    step(noise(), v_decode(op), "decode");
    if (op == OP_ADD || op == OP_AND || op == OP_NOT) begin
      step(noise(), v_alu(op, imm), "alu");
    end else if (op == OP_LDR || op == OP_STR) begin
      step(noise(), v_calc(), "calc_addr");
      if (op == OP_STR) step(noise(), v_str1(), "str1");
      wait_phase((op == OP_LDR) ? 1 : 2, d_mem, f);
      if (f) begin
        fault_tail();
        return;
      end
      if (op == OP_LDR) step(noise(), v_ldr2(), "ldr2");
    end else if (op == OP_BR) begin
      step(noise(), v_br(br), "br");
    end
  endtask

  function automatic int rand_delay();
    return ($urandom_range(0, 15) == 0) ? int'(TMO) + 1 : int'($urandom_range(0, TMO));
  endfunction

  initial begin
    bit f;
    logic [3:0] op;
    reset         = 1'b1;
    opcode        = OP_ADD;
    imm_check     = 1'b0;
    branch_enable = 1'b0;
    mem_resp      = 1'b0;
    #1;
    check("por_reset", obs, v_fetch1());
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed flows
    run_instr(OP_ADD, 1'b1, 1'b0, 1, 0);
    run_instr(OP_LDR, 1'b0, 1'b0, 0, 3);
    run_instr(OP_STR, 1'b0, 1'b0, 2, 2);
    run_instr(OP_BR,  1'b0, 1'b0, 0, 0);
    run_instr(OP_BR,  1'b0, 1'b1, 0, 0);
    run_instr(OP_AND, 1'b0, 1'b1, 0, 0);
    run_instr(OP_NOT, 1'b1, 1'b0, 3, 0);
    run_instr(OP_ADD, 1'b0, 1'b0, int'(TMO) + 1, 0);
    run_instr(OP_ADD, 1'b0, 1'b0, int'(TMO), 0);
    run_instr(4'b1101, 1'b0, 1'b0, 0, 0);
    run_instr(OP_LDR, 1'b0, 1'b0, 0, int'(TMO) + 1);
    run_instr(OP_STR, 1'b0, 1'b0, 0, int'(TMO) + 1);
    run_instr(OP_STR, 1'b0, 1'b0, 0, int'(TMO));

    // Reset asserted mid-way through a load's memory wait
    opcode = OP_LDR;
    step(1'b0, v_fetch1(), "fetch1");
    wait_phase(0, 0, f);
    step(1'b0, v_fetch3(), "fetch3");
    step(1'b0, v_decode(OP_LDR), "decode");
    step(1'b0, v_calc(), "calc_addr");
    step(1'b0, v_wait(1, 1'b0), "ldr1_idle");
    step(1'b0, v_wait(1, 1'b0), "ldr1_idle");
    reset = 1'b1;
    #1;
    check("rst_mid_ldr1", obs, v_fetch1());
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(OP_ADD, 1'b1, 1'b0, 0, 0);

    // Random instruction mix
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 7))
        0: op = OP_ADD;
        1: op = OP_AND;
        2: op = OP_NOT;
        3, 7: op = OP_LDR;
        4: op = OP_STR;
        5: op = OP_BR;
        default: op = 4'($urandom_range(0, 15));
      endcase
      run_instr(op, noise(), noise(), rand_delay(), rand_delay());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
